alu_rr_scheduler: RTL and testbench

- Shares one 8-bit registered add/sub datapath between NUM_REQ requesters using round-robin arbitration.
- Each requester presents a request record (control, a, b) with a valid/ready handshake.
- The block accepts one request, sequences it through the datapath, and holds the tagged result until the consumer accepts it.
- It sits between the requesting engines and the shared arithmetic unit.

---
 rtl/alu_sched_pkg.sv | 52 +++++
 rtl/alu_addsub_core.sv | 38 +++
 rtl/alu_rr_scheduler.sv | 77 +++++++
 tb/tb_alu_rr_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types, op encodings and the round-robin pick used by the ALU scheduler.
package alu_sched_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int MAX_REQ    = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic                  control_in;
        logic [ALU_DATA_W-1:0] a_in;
        logic [ALU_DATA_W-1:0] b_in;
    } alu_req_t;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result_out;
        logic                  flag_out;
    } alu_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } rr_grant_t;

    // First valid requester strictly after 'last', wrapping modulo n.
    // The last-granted requester is only picked again when nobody else asks.
    function automatic rr_grant_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input logic [2:0]         last,
                                          input int unsigned        n);
        rr_grant_t   g;
        int unsigned idx;
        g = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = (32'(last) + k) % n;
                if (!g.hit && valid[idx[2:0]]) begin
                    g.hit = 1'b1;
                    g.idx = idx[2:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/alu_addsub_core.sv
// Shared add/sub datapath: operand register loaded on grant, result registered one cycle later.
module alu_addsub_core
    import alu_sched_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     load,
    input  alu_req_t req,
    output alu_rsp_t rsp
);

    alu_req_t    op_q;
    logic [DATA_W:0] res;

    // Operand capture; holds the granted request so later input changes are ignored.
    always_ff @(posedge clock) begin
        if (reset)     op_q <= '0;
        else if (load) op_q <= req;
    end

    // 9-bit unsigned add/sub; bit DATA_W is carry on add and borrow on sub.
    always_comb begin
        res = '0;
        if (op_q.control_in == OP_SUB)
            res = {1'b0, op_q.a_in} - {1'b0, op_q.b_in};
        else
            res = {1'b0, op_q.a_in} + {1'b0, op_q.b_in};
    end

    // Result register; stays stable while the operand register is untouched.
    always_ff @(posedge clock) begin
        if (reset) rsp <= '0;
        else       rsp <= '{result_out: res[DATA_W-1:0], flag_out: res[DATA_W]};
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one registered add/sub core among NUM_REQ requesters.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = ALU_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  alu_req_t [NUM_REQ-1:0]  req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output alu_rsp_t                rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    sched_state_t    state_q, state_d;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] g_idx;
    rr_grant_t       grant;
    logic            load;

    assign grant = rr_pick(MAX_REQ'(req_valid), 3'(last_grant), NUM_REQ);
    assign g_idx = ID_W'(grant.idx);

    // Next-state and grant decode; reset masks req_ready so nothing is accepted under reset.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant.hit && !reset) begin
                    req_ready[g_idx] = 1'b1;
                    load             = 1'b1;
                    state_d          = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and round-robin pointer; pointer starts at NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            if (load) last_grant <= g_idx;
        end
    end

    // Response tag follows the result into the output register at the end of EXEC.
    always_ff @(posedge clock) begin
        if (reset)                rsp_id <= '0;
        else if (state_q == EXEC) rsp_id <= last_grant;
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    alu_addsub_core #(.DATA_W(DATA_W)) u_core (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .req   (req_data[g_idx]),
        .rsp   (rsp_data)
    );

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: a reference FSM/RR model predicts grants and results.
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;

    localparam int N = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    alu_req_t [N-1:0]    req_data;
    logic                rsp_valid;
    logic                rsp_ready;
    alu_rsp_t            rsp_data;
    logic [1:0]          rsp_id;
    logic                busy;

    always #5 clock = ~clock;

    alu_rr_scheduler #(.NUM_REQ(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    typedef struct packed {
        logic [1:0] id;
        logic       flag;
        logic [7:0] res;
    } exp_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb_q[$];
    exp_t rsp_log[$];
    int   g_id_log[$];
    int   g_cyc_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model_op(input alu_req_t r, input int id);
        logic [8:0] s;
        if (r.control_in) s = {1'b0, r.a_in} - {1'b0, r.b_in};
        else              s = {1'b0, r.a_in} + {1'b0, r.b_in};
        return '{id: 2'(id), flag: s[8], res: s[7:0]};
    endfunction

    // Reference model, sampled on the falling edge while inputs are stable.
    int   cyc = 0;
    int   m_state = 0;
    int   m_last = N - 1;
    int   g, obs, ii;
    logic [N-1:0] exp_rdy;
    exp_t e;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            m_state = 0;
            m_last  = N - 1;
            sb_q.delete();
        end else begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            case (m_state)
                0: begin
                    g = -1;
                    for (int k = 1; k <= N; k++) begin
                        ii = (m_last + k) % N;
                        if (g < 0 && req_valid[ii]) g = ii;
                    end
                    exp_rdy = '0;
                    if (g >= 0) exp_rdy[g] = 1'b1;
                    chk("idle_req_ready", 32'(req_ready), 32'(exp_rdy));
                    chk("idle_busy", 32'(busy), 0);
                    chk("idle_rsp_valid", 32'(rsp_valid), 0);
                    if (g >= 0) begin
                        obs = -1;
                        for (int k = N - 1; k >= 0; k--) if (req_ready[k]) obs = k;
                        sb_q.push_back(model_op(req_data[g], g));
                        g_id_log.push_back(obs);
                        g_cyc_log.push_back(cyc);
                        m_last  = g;
                        m_state = 1;
                    end
                end
                1: begin
                    chk("exec_req_ready", 32'(req_ready), 0);
                    chk("exec_busy", 32'(busy), 1);
                    chk("exec_rsp_valid", 32'(rsp_valid), 0);
                    m_state = 2;
                end
                default: begin
                    chk("resp_rsp_valid", 32'(rsp_valid), 1);
                    chk("resp_req_ready", 32'(req_ready), 0);
                    chk("resp_busy", 32'(busy), 1);
                    if (sb_q.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        e = sb_q[0];
                        chk("rsp_data", 32'(rsp_data), 32'({e.res, e.flag}));
                        chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    end
                    if (rsp_ready) begin
                        rsp_log.push_back('{id: rsp_id, flag: rsp_data.flag_out, res: rsp_data.result_out});
                        if (sb_q.size() != 0) void'(sb_q.pop_front());
                        m_state = 0;
                    end
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_grants(input int target);
        int t;
        t = 0;
        while (g_id_log.size() < target && t < 200) begin
            tick(1);
            t++;
        end
        chk("grant_wait", 32'(g_id_log.size() >= target), 1);
    endtask

    // Compare a run of grants against an expected id list, each 3 cycles after the previous.
    task automatic chk_grants(input string tag, input int base, input int cnt, input int ids[5]);
        for (int k = 0; k < cnt; k++) begin
            if (base + k >= g_id_log.size()) begin
                chk({tag, "_missing"}, 0, 1);
            end else begin
                chk({tag, "_id"}, 32'(g_id_log[base + k]), 32'(ids[k]));
                if (k > 0) chk({tag, "_gap"}, 32'(g_cyc_log[base + k] - g_cyc_log[base + k - 1]), 3);
            end
        end
    endtask

    function automatic alu_req_t mk(input logic c, input logic [7:0] a, input logic [7:0] b);
        return '{control_in: c, a_in: a, b_in: b};
    endfunction

    int base;
    int nrsp;

    initial begin
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        tick(3);

        // reset state, and req_ready masked even with requests pending
        req_valid = '1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_busy", 32'(busy), 0);
        req_valid = '0;
        tick(1);
        reset     = 1'b0;
        rsp_ready = 1'b1;

        // add with carry out; ready asserted combinationally in the request cycle
        req_data[0] = mk(OP_ADD, 8'hF0, 8'h20);
        req_valid   = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 1);
        tick(1);
        req_valid = '0;
        tick(4);
        chk("t1_count", 32'(rsp_log.size()), 1);
        if (rsp_log.size() >= 1) chk("t1_rsp", 32'(rsp_log[0]), 32'({2'd0, 1'b1, 8'h10}));

        // subtract with and without borrow
        req_data[2] = mk(OP_SUB, 8'h05, 8'h07);
        req_valid   = 4'b0100;
        tick(1);
        req_valid = '0;
        tick(4);
        req_data[2] = mk(OP_SUB, 8'h07, 8'h05);
        req_valid   = 4'b0100;
        tick(1);
        req_valid = '0;
        tick(4);
        chk("t2_count", 32'(rsp_log.size()), 3);
        if (rsp_log.size() >= 3) begin
            chk("t2_borrow", 32'(rsp_log[1]), 32'({2'd2, 1'b1, 8'hFE}));
            chk("t2_noborrow", 32'(rsp_log[2]), 32'({2'd2, 1'b0, 8'h02}));
        end

        // reset during EXEC discards the result and restores requester 0 priority
        nrsp        = rsp_log.size();
        req_data[1] = mk(OP_ADD, 8'hFF, 8'h01);
        req_valid   = 4'b0010;
        tick(1);
        req_valid = '0;
        reset     = 1'b1;
        tick(1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        reset = 1'b0;
        tick(5);
        chk("abort_no_rsp", 32'(rsp_log.size()), 32'(nrsp));

        // all requesters valid; data scrambled every cycle after each grant
        base      = g_id_log.size();
        nrsp      = rsp_log.size();
        req_valid = '1;
        for (int c = 0; c < 15; c++) begin
            for (int r = 0; r < N; r++)
                req_data[r] = mk(1'($urandom), 8'($urandom), 8'($urandom));
            tick(1);
        end
        req_valid = '0;
        tick(4);
        chk_grants("all_valid", base, 5, '{0, 1, 2, 3, 0});
        chk("all_valid_rsps", 32'(rsp_log.size() - nrsp), 5);

        // backpressure: result held, no new grant despite pending requests
        req_data[3] = mk(OP_ADD, 8'h80, 8'h80);
        req_valid   = 4'b1000;
        rsp_ready   = 1'b0;
        tick(1);
        req_valid = 4'b0011;
        tick(1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_data", 32'(rsp_data), 32'({8'h00, 1'b1}));
            chk("bp_rsp_id", 32'(rsp_id), 3);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_busy", 32'(busy), 1);
            tick(1);
        end
        rsp_ready = 1'b1;
        tick(1);
        chk("bp_release", 32'(rsp_valid), 0);
        tick(1);
        req_valid = '0;
        tick(4);

        // put the pointer on 3, then 0..2, then only 3 (no gap), then wrap to 0
        req_valid = 4'b1000;
        tick(1);
        req_valid = '0;
        tick(4);
        base      = g_id_log.size();
        req_valid = 4'b0111;
        wait_grants(base + 3);
        req_valid = 4'b1000;
        wait_grants(base + 4);
        req_valid = 4'b1111;
        wait_grants(base + 5);
        req_valid = '0;
        tick(4);
        chk_grants("wrap", base, 5, '{0, 1, 2, 3, 0});

        // single requester held valid is served back to back
        base      = g_id_log.size();
        req_valid = 4'b0010;
        tick(9);
        req_valid = '0;
        tick(4);
        chk_grants("single", base, 3, '{1, 1, 1, 0, 0});
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
